uart_prog_loader: RTL
=====================

// Module: uart_prog_loader
// PURPOSE
// RS232 program loader sitting upstream of the MPU. It receives a framed program image on the serial line,
// assembles big-endian 32-bit words and writes them into the shared RAM. It holds the CPU frozen during the
// load, then pulses a CPU reset so execution restarts at address 0.
// PARAMETERS
// CLKS_PER_BIT  434    clocks per UART bit (50 MHz / 115200); 8N1, LSB first
// ADDR_W        10     RAM address width; matches the MPU's SIZE
// TIMEOUT       65535  max idle clocks between bytes once a frame has started
// SYNC_BYTE     8'hA5  frame start marker
// PORTS
// clk         input   1       system clock
// rst         input   1       asynchronous active-low reset (0 = reset)
// rx          input   1       UART serial input, idle high, asynchronous to clk
// wrEn        output  1       RAM write strobe, one cycle per word
// addr_toRAM  output  ADDR_W  RAM write address
// data_toRAM  output  32      RAM write data
// freezeFlag  output  1       high = CPU halted (drives MPU freezeFlag)
// cpu_rst     output  1       one-cycle active-high pulse to MPU rst after a good load
// load_done   output  1       sticky: last load completed; cleared at next SYNC
// load_err    output  1       sticky: last load aborted; cleared at next SYNC
// BEHAVIOUR
// - Reset (rst=0, async): every output 0; FSM in IDLE; byte/word counters 0. A load in progress is discarded.
//   freezeFlag=0 after reset, so a RAM preloaded image runs.
// - Frame format: SYNC_BYTE, CNT_HI, CNT_LO, then N=(CNT_HI:CNT_LO) words of 4 bytes each, MSB byte first.
//   Word k is written to address k, for k = 0..N-1.
// - RX byte engine:
//   - rx passes through a 2-FF synchroniser.
//   - A falling edge starts a bit counter; the start bit is re-checked at CLKS_PER_BIT/2 and must still read 0,
//     otherwise it is a false start and is ignored.
//   - Data bits are sampled at mid-bit; the stop bit is sampled at mid-bit.
//   - Stop=1: byte_valid pulses for 1 clk. Stop=0: frame_err pulses for 1 clk.
// - Loader FSM:
//   - IDLE: bytes other than SYNC_BYTE are ignored. On SYNC: freezeFlag=1, clear load_done/load_err, go to CNT_HI.
//   - CNT_HI -> CNT_LO: latch count.
//     - N > 2**ADDR_W: go to ERR with no write.
//     - N == 0: go to RELEASE.
//     - Otherwise go to DATA.
//   - DATA: shift each byte in, data = {data[23:0], byte}. After the 4th byte go to WRITE.
//   - WRITE (1 clk): wrEn=1, addr_toRAM=word_idx, data_toRAM=assembled word; increment word_idx.
//     If word_idx == N-1 go to RELEASE, else go to DATA.
//     wrEn rises on the clock after the 4th byte's byte_valid.
//   - RELEASE (1 clk): freezeFlag=0, cpu_rst=1, load_done=1, then IDLE.
//     cpu_rst coincides with freeze deassert; the MPU loads pCounter=0 that cycle.
//   - ERR (1 clk): load_err=1, then IDLE. freezeFlag stays 1 until a later load reaches RELEASE or rst.
//     The CPU never runs a partial image.
// - Abort to ERR from CNT_HI, CNT_LO or DATA on:
//   - frame_err;
//   - inter-byte idle counter reaching TIMEOUT. The counter resets on every byte_valid and runs only outside IDLE.
// - A SYNC_BYTE value received inside a frame is treated as data, not as a restart.
// - addr_toRAM/data_toRAM hold their last values when wrEn=0. wrEn is never high in IDLE, ERR or RELEASE.
// - Word count is ADDR_W+1 bits wide internally so N = 2**ADDR_W is legal and addresses wrap nowhere.
// STRUCTURE
// - Shared package vscpu_pkg: loader state encodings (IDLE, CNT_HI, CNT_LO, DATA, WRITE, RELEASE, ERR) and
//   SYNC_BYTE; the MPU opcode constants belong there too.
// - Sub-module uart_rx (CLKS_PER_BIT): rx in; byte_valid, byte_data[7:0], frame_err out.
//   The loader FSM, counters and timeout live in this module.
// TESTING (sim with CLKS_PER_BIT=4, TIMEOUT=200)
// 1. Send A5 00 02 12 34 56 78 9A BC DE F0 -> exactly two wrEn pulses: (0, 32'h12345678), (1, 32'h9ABCDEF0).
//    freezeFlag high from SYNC to RELEASE; single cpu_rst pulse; load_done=1.
// 2. Idle line, send 3C then a 1-clk low glitch on rx -> no wrEn, freezeFlag stays 0, no flags.
// 3. A5 00 01 11 22, then a byte with stop bit 0 -> load_err=1, no wrEn, freezeFlag stays 1, no cpu_rst.
//    Then a full good frame -> freeze released.
// 4. ADDR_W=10, send A5 04 01 -> ERR after CNT_LO, zero writes. A5 00 00 -> immediate RELEASE, cpu_rst, no writes.
// 5. A5 00 01 AA, then 200 idle clocks -> load_err=1 on the timeout, no write.
// 6. Assert rst low mid-DATA (after 2 bytes) -> all outputs 0 asynchronously.
//    After release, a complete frame loads correctly from address 0.

Source files
------------

// File: rtl/vscpu_pkg.sv
// Shared definitions for the VSCPU program loader and MPU.
// Holds the loader state encoding, the frame start marker and a small helper
// used to decide which loader states belong to an open frame.
package vscpu_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CNT_HI  = 3'd1,
    CNT_LO  = 3'd2,
    DATA    = 3'd3,
    WRITE   = 3'd4,
    RELEASE = 3'd5,
    ERR     = 3'd6
  } ld_state_t;

  // States that are waiting on the serial line and may therefore be aborted
  // by a framing error or an inter-byte timeout.
  function automatic logic in_frame(input ld_state_t s);
    return (s == CNT_HI) || (s == CNT_LO) || (s == DATA);
  endfunction

endpackage

// File: rtl/uart_prog_loader_if.sv
// RAM write port between the program loader and the shared program RAM.
//   wrEn        one-cycle write strobe per 32-bit word
//   addr_toRAM  word address (ADDR_W bits)
//   data_toRAM  word data (32 bits)
// master: loader side, slave: RAM side.
interface uart_prog_loader_if #(
  parameter int ADDR_W = 10
);
  logic              wrEn;
  logic [ADDR_W-1:0] addr_toRAM;
  logic [31:0]       data_toRAM;

  modport master (output wrEn, output addr_toRAM, output data_toRAM);
  modport slave  (input  wrEn, input  addr_toRAM, input  data_toRAM);
endinterface

// File: rtl/uart_prog_loader_rx.sv
// 8N1 UART receiver, LSB first.
//   clk, rst    system clock, asynchronous active-low reset
//   rx          serial input, idle high, asynchronous to clk
//   byte_valid  one-cycle pulse when a byte with a good stop bit arrives
//   byte_data   last received byte (held between bytes)
//   frame_err   one-cycle pulse when the stop bit reads 0
//
// state    | meaning
// RX_IDLE  | waiting for a falling edge on the synchronised line
// RX_START | half-bit wait, start bit re-checked to reject glitches
// RX_BITS  | eight data bits, each sampled at mid-bit
// RX_STOP  | stop bit sampled at mid-bit
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;

  rx_state_t        state, state_nxt;
  logic             rx_meta, rx_s, rx_d;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_nxt;
  logic [7:0]       shreg, sh_nxt;
  logic             valid_nxt, ferr_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // Synchroniser starts at the idle level so reset release is not a start edge.
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      rx_d       <= 1'b1;
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_s       <= rx_meta;
      rx_d       <= rx_s;
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bit_idx    <= bit_nxt;
      shreg      <= sh_nxt;
      byte_valid <= valid_nxt;
      frame_err  <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_idx;
    sh_nxt    = shreg;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
    case (state)
      RX_IDLE: begin
        if (rx_d && !rx_s) begin
          state_nxt = RX_START;
          cnt_nxt   = HALF;
        end
      end
      RX_START: begin
        if (cnt == '0) begin
          if (!rx_s) begin
            state_nxt = RX_BITS;
            cnt_nxt   = FULL;
            bit_nxt   = '0;
          end else begin
            state_nxt = RX_IDLE;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      RX_BITS: begin
        if (cnt == '0) begin
          sh_nxt  = {rx_s, shreg[7:1]};
          cnt_nxt = FULL;
          if (bit_idx == 3'd7) state_nxt = RX_STOP;
          else                 bit_nxt   = bit_idx + 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt == '0) begin
          state_nxt = RX_IDLE;
          if (rx_s) valid_nxt = 1'b1;
          else      ferr_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  assign byte_data = shreg;

endmodule

// File: rtl/uart_prog_loader.sv
// Serial program loader in front of the MPU. Receives SYNC, a 16-bit word
// count and big-endian 32-bit words, writes word k to RAM address k, keeps the
// CPU frozen during the load and pulses cpu_rst once the image is complete.
//   clk, rst    system clock, asynchronous active-low reset
//   rx          UART serial input
//   ram         RAM write port (wrEn, addr_toRAM, data_toRAM)
//   freezeFlag  high while the CPU must stay halted
//   cpu_rst     one-cycle pulse after a good load
//   load_done   sticky, last load completed
//   load_err    sticky, last load aborted
//
// state   | meaning
// IDLE    | hunting for SYNC_BYTE, other bytes ignored
// CNT_HI  | waiting for the count high byte
// CNT_LO  | waiting for the count low byte, range-checks N
// DATA    | collecting four bytes of the current word
// WRITE   | one-cycle RAM write of the assembled word
// RELEASE | one cycle: unfreeze, pulse cpu_rst, set load_done
// ERR     | one cycle: set load_err, CPU stays frozen
module uart_prog_loader #(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          ADDR_W       = 10,
  parameter int          TIMEOUT      = 65535,
  parameter logic [7:0]  SYNC_BYTE    = vscpu_pkg::SYNC_BYTE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx,
  uart_prog_loader_if.master  ram,
  output logic                freezeFlag,
  output logic                cpu_rst,
  output logic                load_done,
  output logic                load_err
);

  import vscpu_pkg::*;

  // One extra bit so a full RAM (N = 2**ADDR_W) is representable.
  localparam int CNT_W = ADDR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD  = TMO_W'(TIMEOUT);
  localparam logic [31:0]      MAX_WORDS = 32'(2 ** ADDR_W);

  logic        byte_valid, frame_err;
  logic [7:0]  byte_data;

  ld_state_t         state, state_nxt;
  logic [7:0]        cnt_hi, cnt_hi_nxt;
  logic [CNT_W-1:0]  n_words, n_nxt;
  logic [CNT_W-1:0]  word_idx, idx_nxt;
  logic [1:0]        byte_cnt, bcnt_nxt;
  logic [23:0]       sh, sh_nxt;
  logic [TMO_W-1:0]  tmo, tmo_nxt;
  logic              wr_q, wr_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [31:0]       data_q, data_nxt;
  logic              freeze_nxt, cpu_rst_nxt, done_nxt, err_nxt;
  logic [15:0]       cnt_full;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  assign cnt_full = {cnt_hi, byte_data};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt_hi     <= '0;
      n_words    <= '0;
      word_idx   <= '0;
      byte_cnt   <= '0;
      sh         <= '0;
      tmo        <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      freezeFlag <= 1'b0;
      cpu_rst    <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt_hi     <= cnt_hi_nxt;
      n_words    <= n_nxt;
      word_idx   <= idx_nxt;
      byte_cnt   <= bcnt_nxt;
      sh         <= sh_nxt;
      tmo        <= tmo_nxt;
      wr_q       <= wr_nxt;
      addr_q     <= addr_nxt;
      data_q     <= data_nxt;
      freezeFlag <= freeze_nxt;
      cpu_rst    <= cpu_rst_nxt;
      load_done  <= done_nxt;
      load_err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_hi_nxt  = cnt_hi;
    n_nxt       = n_words;
    idx_nxt     = word_idx;
    bcnt_nxt    = byte_cnt;
    sh_nxt      = sh;
    tmo_nxt     = tmo;
    wr_nxt      = 1'b0;
    addr_nxt    = addr_q;
    data_nxt    = data_q;
    freeze_nxt  = freezeFlag;
    cpu_rst_nxt = 1'b0;
    done_nxt    = load_done;
    err_nxt     = load_err;

    // Inter-byte watchdog: reloaded on every byte and held loaded while idle.
    if (state == IDLE || byte_valid) tmo_nxt = TMO_LOAD;
    else if (tmo != '0)              tmo_nxt = tmo - 1'b1;

    if (in_frame(state) && (frame_err || tmo == '0)) begin
      state_nxt = ERR;
      err_nxt   = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (byte_valid && byte_data == SYNC_BYTE) begin
            state_nxt  = CNT_HI;
            freeze_nxt = 1'b1;
            done_nxt   = 1'b0;
            err_nxt    = 1'b0;
            idx_nxt    = '0;
            bcnt_nxt   = '0;
          end
        end
        CNT_HI: begin
          if (byte_valid) begin
            cnt_hi_nxt = byte_data;
            state_nxt  = CNT_LO;
          end
        end
        CNT_LO: begin
          if (byte_valid) begin
            n_nxt = CNT_W'(cnt_full);
            if ({16'd0, cnt_full} > MAX_WORDS) begin
              state_nxt = ERR;
              err_nxt   = 1'b1;
            end else if (cnt_full == 16'd0) begin
              state_nxt   = RELEASE;
              freeze_nxt  = 1'b0;
              cpu_rst_nxt = 1'b1;
              done_nxt    = 1'b1;
            end else begin
              state_nxt = DATA;
            end
          end
        end
        DATA: begin
          if (byte_valid) begin
            sh_nxt   = {sh[15:0], byte_data};
            bcnt_nxt = byte_cnt + 1'b1;
            if (byte_cnt == 2'd3) begin
              state_nxt = WRITE;
              wr_nxt    = 1'b1;
              addr_nxt  = word_idx[ADDR_W-1:0];
              data_nxt  = {sh, byte_data};
            end
          end
        end
        WRITE: begin
          idx_nxt = word_idx + 1'b1;
          if (word_idx == n_words - 1'b1) begin
            state_nxt   = RELEASE;
            freeze_nxt  = 1'b0;
            cpu_rst_nxt = 1'b1;
            done_nxt    = 1'b1;
          end else begin
            state_nxt = DATA;
          end
        end
        RELEASE: state_nxt = IDLE;
        ERR:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign ram.wrEn       = wr_q;
  assign ram.addr_toRAM = addr_q;
  assign ram.data_toRAM = data_q;

endmodule
